// File: rtl/pc_source_reg.sv
// Next-PC source selector with integrated PC register. Holds the PC under stall
// and buffers the last valid redirect seen during a stall until release.
module pc_source_reg #(
    parameter int               WIDTH    = 32,
    parameter int               N_SRC    = 4,
    parameter int               SEL_W    = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_SRC*WIDTH-1:0] src_bus,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   step,
    input  logic                   stall,
    output logic [WIDTH-1:0]       pc,
    output logic [WIDTH-1:0]       pc_prev,
    output logic                   pc_update,
    output logic                   redirect_pending,
    output logic                   sel_err
);

    logic [WIDTH-1:0] w_cand;
    logic             w_sel_ok;
    logic             w_step_ok;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_pc_prev;
    logic             r_pc_update;
    logic             r_pending;
    logic [WIDTH-1:0] r_pend_val;
    logic             r_sel_err;

    // Explicit compare mux: out-of-range selects yield zero instead of an out-of-bounds slice.
    always_comb begin
        w_cand = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel == SEL_W'(i))
                w_cand = src_bus[i*WIDTH +: WIDTH];
        end
    end

    assign w_sel_ok  = (32'(sel) < N_SRC);
    assign w_step_ok = step & w_sel_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_pc_prev   <= RESET_PC;
            r_pc_update <= 1'b0;
            r_pending   <= 1'b0;
            r_pend_val  <= '0;
            r_sel_err   <= 1'b0;
        end else begin
            r_pc_update <= 1'b0;
            if (step && !w_sel_ok)
                r_sel_err <= 1'b1;
            // A bad select suppresses everything this cycle, including a pending apply.
            if (w_step_ok && !stall) begin
                r_pc        <= w_cand;
                r_pc_prev   <= r_pc;
                r_pc_update <= 1'b1;
                r_pending   <= 1'b0;
            end else if (w_step_ok && stall) begin
                r_pend_val  <= w_cand;
                r_pending   <= 1'b1;
            end else if (!step && !stall && r_pending) begin
                r_pc        <= r_pend_val;
                r_pc_prev   <= r_pc;
                r_pc_update <= 1'b1;
                r_pending   <= 1'b0;
            end
        end
    end

    assign pc               = r_pc;
    assign pc_prev          = r_pc_prev;
    assign pc_update        = r_pc_update;
    assign redirect_pending = r_pending;
    assign sel_err          = r_sel_err;

endmodule

// File: tb/tb_pc_source_reg.sv
// Bench for pc_source_reg: a 4-source and a 3-source instance share stimulus;
// expected results are queued when driven and compared after the edge.
module tb_pc_source_reg;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              step = 1'b0;
    logic              stall = 1'b0;
    logic [1:0]        sel = '0;
    logic [3:0][31:0]  src = '0;

    logic [31:0] pc4, prev4, pc3, prev3;
    logic        upd4, pend4, err4, upd3, pend3, err3;

    always #5 clk = ~clk;

    pc_source_reg #(.WIDTH(32), .N_SRC(4), .SEL_W(2), .RESET_PC(32'h0)) u_dut4 (
        .clk(clk), .rst(rst), .src_bus(src), .sel(sel), .step(step), .stall(stall),
        .pc(pc4), .pc_prev(prev4), .pc_update(upd4), .redirect_pending(pend4), .sel_err(err4)
    );

    pc_source_reg #(.WIDTH(32), .N_SRC(3), .SEL_W(2), .RESET_PC(32'h0)) u_dut3 (
        .clk(clk), .rst(rst), .src_bus(src[2:0]), .sel(sel), .step(step), .stall(stall),
        .pc(pc3), .pc_prev(prev3), .pc_update(upd3), .redirect_pending(pend3), .sel_err(err3)
    );

    typedef struct {
        string       nm;
        logic        r, sp, sl;
        logic [1:0]  s;
        int          slot;
        logic [31:0] val;
        logic [31:0] pc, prev;
        logic        upd, pend, err;
    } vec_t;

    typedef struct {
        string       nm;
        bit          d3;
        logic [31:0] pc, prev;
        logic        upd, pend, err;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, got, want);
        end
    endtask

    // Drive one cycle, queue its expectation, then check at edge+1.
    task automatic cycle(input vec_t v, input bit d3);
        exp_t e, g;
        rst = v.r; step = v.sp; stall = v.sl; sel = v.s;
        if (v.slot >= 0 && v.slot < 4) src[v.slot] = v.val;
        e.nm = v.nm; e.d3 = d3; e.pc = v.pc; e.prev = v.prev;
        e.upd = v.upd; e.pend = v.pend; e.err = v.err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL %s: scoreboard empty", v.nm);
        end else begin
            g = sb.pop_front();
            if (g.d3) begin
                cmp(g.nm, "pc", pc3, g.pc);
                cmp(g.nm, "pc_prev", prev3, g.prev);
                cmp(g.nm, "pc_update", 32'(upd3), 32'(g.upd));
                cmp(g.nm, "pending", 32'(pend3), 32'(g.pend));
                cmp(g.nm, "sel_err", 32'(err3), 32'(g.err));
            end else begin
                cmp(g.nm, "pc", pc4, g.pc);
                cmp(g.nm, "pc_prev", prev4, g.prev);
                cmp(g.nm, "pc_update", 32'(upd4), 32'(g.upd));
                cmp(g.nm, "pending", 32'(pend4), 32'(g.pend));
                cmp(g.nm, "sel_err", 32'(err4), 32'(g.err));
            end
        end
    endtask

    function automatic vec_t mk(input string nm, input logic r, input logic sp, input logic sl,
                                input logic [1:0] s, input int slot, input logic [31:0] val,
                                input logic [31:0] pc, input logic [31:0] prev,
                                input logic upd, input logic pend, input logic err);
        vec_t v;
        v.nm = nm; v.r = r; v.sp = sp; v.sl = sl; v.s = s; v.slot = slot; v.val = val;
        v.pc = pc; v.prev = prev; v.upd = upd; v.pend = pend; v.err = err;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] last_pc;
        logic [31:0] last_prev;
        logic [1:0]  s;
        //            name        rst step stall sel slot  value        pc           prev        upd pend err
        tbl.push_back(mk("rst0",   1, 1, 0, 2'd1, 1, 32'h100, 32'h0,   32'h0,   0, 0, 0));
        tbl.push_back(mk("rst1",   1, 1, 0, 2'd1, 1, 32'h100, 32'h0,   32'h0,   0, 0, 0));
        tbl.push_back(mk("seq4",   0, 1, 0, 2'd0, 0, 32'h4,   32'h4,   32'h0,   1, 0, 0));
        tbl.push_back(mk("seq8",   0, 1, 0, 2'd0, 0, 32'h8,   32'h8,   32'h4,   1, 0, 0));
        tbl.push_back(mk("seqC",   0, 1, 0, 2'd0, 0, 32'hC,   32'hC,   32'h8,   1, 0, 0));
        tbl.push_back(mk("idle",   0, 0, 0, 2'd0, -1, 32'h0,  32'hC,   32'h8,   0, 0, 0));
        tbl.push_back(mk("stl400", 0, 1, 1, 2'd2, 2, 32'h400, 32'hC,   32'h8,   0, 1, 0));
        tbl.push_back(mk("stl800", 0, 1, 1, 2'd3, 3, 32'h800, 32'hC,   32'h8,   0, 1, 0));
        tbl.push_back(mk("stlhold",0, 0, 1, 2'd0, -1, 32'h0,  32'hC,   32'h8,   0, 1, 0));
        tbl.push_back(mk("release",0, 0, 0, 2'd0, -1, 32'h0,  32'h800, 32'hC,   1, 0, 0));
        tbl.push_back(mk("postrel",0, 0, 0, 2'd0, -1, 32'h0,  32'h800, 32'hC,   0, 0, 0));
        tbl.push_back(mk("ovpend", 0, 1, 1, 2'd3, 3, 32'h900, 32'h800, 32'hC,   0, 1, 0));
        tbl.push_back(mk("ovstep", 0, 1, 0, 2'd1, 1, 32'h200, 32'h200, 32'h800, 1, 0, 0));
        tbl.push_back(mk("ovafter",0, 0, 0, 2'd0, -1, 32'h0,  32'h200, 32'h800, 0, 0, 0));
        tbl.push_back(mk("samepc", 0, 1, 0, 2'd1, 1, 32'h200, 32'h200, 32'h200, 1, 0, 0));
        tbl.push_back(mk("stlidle",0, 0, 1, 2'd0, -1, 32'h0,  32'h200, 32'h200, 0, 0, 0));

        @(negedge clk);
        foreach (tbl[i]) cycle(tbl[i], 1'b0);

        // Invalid select on the 3-source instance; sel_err must stay sticky.
        cycle(mk("d3rst",  1, 0, 0, 2'd0, -1, 32'h0, 32'h0,  32'h0, 0, 0, 0), 1'b1);
        cycle(mk("d3ld",   0, 1, 0, 2'd0, 0, 32'h10, 32'h10, 32'h0, 1, 0, 0), 1'b1);
        cycle(mk("d3bad",  0, 1, 0, 2'd3, 3, 32'hBAD, 32'h10, 32'h0, 0, 0, 1), 1'b1);
        last_pc = 32'h10; last_prev = 32'h0;
        for (int i = 0; i < 10; i++) begin
            s = 2'(i % 3);
            cycle(mk($sformatf("d3ok%0d", i), 0, 1, 0, s, int'(s), 32'h1000 + 32'(i*4),
                     32'h1000 + 32'(i*4), last_pc, 1, 0, 1), 1'b1);
            last_prev = last_pc;
            last_pc   = 32'h1000 + 32'(i*4);
        end
        cycle(mk("d3clr",  1, 0, 0, 2'd0, -1, 32'h0, 32'h0, 32'h0, 0, 0, 0), 1'b1);

        // Reset arriving mid-stall drops the buffered redirect.
        cycle(mk("mspend", 0, 1, 1, 2'd2, 2, 32'h400, 32'h0, 32'h0, 0, 1, 0), 1'b0);
        cycle(mk("msrst",  1, 0, 1, 2'd0, -1, 32'h0,  32'h0, 32'h0, 0, 0, 0), 1'b0);
        cycle(mk("msrel",  0, 0, 0, 2'd0, -1, 32'h0,  32'h0, 32'h0, 0, 0, 0), 1'b0);
        cycle(mk("msrel2", 0, 0, 0, 2'd0, -1, 32'h0,  32'h0, 32'h0, 0, 0, 0), 1'b0);

        if (sb.size() != 0) begin
            n_chk++; n_err++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
